pwm_multi: RTL and testbench

Multi-channel PWM generator with CH outputs sharing one period counter. It adds a clock prescaler, edge- and center-aligned counting, per-channel output polarity, and shadow-register updates that are glitch-free at period boundaries. Duty and period are given in counter ticks, not percent. It is the general PWM engine for motor, LED and servo drivers in the design, and is programmed by a host-side register block through a load/ack handshake.

---
 rtl/pwm_multi.sv | 143 ++++++++++++++
 tb/tb_pwm_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM engine: shared prescaled period counter (edge/center), per-channel compare, shadowed config.
// Outputs are registered one clock after the counter state they reflect; no backpressure, load is always accepted.
module pwm_multi #(
   parameter int CH    = 4,
   parameter int CNT_W = 16,
   parameter int PSC_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_i,
   input  logic                mode_i,
   input  logic [CNT_W-1:0]    period_i,
   input  logic [CH*CNT_W-1:0] duty_i,
   input  logic [CH-1:0]       pol_i,
   input  logic [PSC_W-1:0]    psc_i,
   input  logic                load_i,
   output logic                load_ack_o,
   output logic [CH-1:0]       pwm_o,
   output logic [CNT_W-1:0]    cnt_o,
   output logic                period_end_o
);

   logic [PSC_W-1:0]    r_psc;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_down;
   logic                r_pend;
   logic                r_st_mode;
   logic [CNT_W-1:0]    r_st_period;
   logic [CH*CNT_W-1:0] r_st_duty;
   logic [CH-1:0]       r_st_pol;
   logic                r_mode;
   logic [CNT_W-1:0]    r_period;
   logic [CH*CNT_W-1:0] r_duty;
   logic [CH-1:0]       r_pol;
   logic [CH-1:0]       r_pwm;
   logic                r_pe;
   logic                r_ack;

   logic                w_tick;
   logic                w_last;
   logic                w_bnd;
   logic                w_xfer;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic                w_down_nxt;
   logic [CH-1:0]       w_raw;

   always_comb begin
      w_tick     = en_i && (r_psc == psc_i);
      w_last     = 1'b0;
      w_cnt_nxt  = r_cnt;
      w_down_nxt = r_down;
      // r_down is set on arrival at P, so in center mode the 1->0 step is the last tick
      if (r_period == '0)
         w_last = 1'b1;
      else if (r_mode)
         w_last = r_down && (r_cnt == CNT_W'(1));
      else
         w_last = (r_cnt >= r_period);

      if (w_last) begin
         w_cnt_nxt  = '0;
         w_down_nxt = 1'b0;
      end else if (r_mode && r_down) begin
         w_cnt_nxt  = r_cnt - CNT_W'(1);
         w_down_nxt = 1'b1;
      end else if (r_mode) begin
         w_cnt_nxt  = r_cnt + CNT_W'(1);
         w_down_nxt = ((r_cnt + CNT_W'(1)) == r_period);
      end else begin
         w_cnt_nxt  = r_cnt + CNT_W'(1);
         w_down_nxt = 1'b0;
      end

      w_bnd  = w_tick && w_last;
      w_xfer = r_pend && (w_bnd || !en_i);

      w_raw = '0;
      for (int k = 0; k < CH; k++)
         w_raw[k] = (r_cnt < r_duty[k*CNT_W +: CNT_W]);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_psc       <= '0;
         r_cnt       <= '0;
         r_down      <= 1'b0;
         r_pend      <= 1'b0;
         r_st_mode   <= 1'b0;
         r_st_period <= '0;
         r_st_duty   <= '0;
         r_st_pol    <= '0;
         r_mode      <= 1'b0;
         r_period    <= '0;
         r_duty      <= '0;
         r_pol       <= '0;
         r_pwm       <= '0;
         r_pe        <= 1'b0;
         r_ack       <= 1'b0;
      end else begin
         r_ack <= w_xfer;
         r_pe  <= w_bnd;
         r_pwm <= en_i ? (w_raw ^ r_pol) : r_pol;

         if (!en_i) begin
            r_psc  <= '0;
            r_cnt  <= '0;
            r_down <= 1'b0;
         end else if (w_tick) begin
            r_psc  <= '0;
            r_cnt  <= w_cnt_nxt;
            r_down <= w_down_nxt;
         end else begin
            r_psc <= r_psc + PSC_W'(1);
         end

         // Transfer takes the old staging contents even if load_i hits the same edge
         if (w_xfer) begin
            r_mode   <= r_st_mode;
            r_period <= r_st_period;
            r_duty   <= r_st_duty;
            r_pol    <= r_st_pol;
            r_cnt    <= '0;
            r_down   <= 1'b0;
         end

         if (load_i) begin
            r_st_mode   <= mode_i;
            r_st_period <= period_i;
            r_st_duty   <= duty_i;
            r_st_pol    <= pol_i;
            r_pend      <= 1'b1;
         end else if (w_xfer) begin
            r_pend <= 1'b0;
         end
      end
   end

   assign load_ack_o   = r_ack;
   assign pwm_o        = r_pwm;
   assign cnt_o        = r_cnt;
   assign period_end_o = r_pe;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: phase-index reference model compared every cycle, plus directed window counts.
module tb_pwm_multi;
   localparam int CH = 4;
   localparam int CNT_W = 16;
   localparam int PSC_W = 8;

   logic clk = 1'b0;
   logic rst, en, mode, load;
   logic [CNT_W-1:0] period;
   logic [CH*CNT_W-1:0] duty;
   logic [CH-1:0] pol;
   logic [PSC_W-1:0] psc;
   logic ack, pe;
   logic [CH-1:0] pwm;
   logic [CNT_W-1:0] cnt;

   pwm_multi #(.CH(CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
      .clk(clk), .rst(rst), .en_i(en), .mode_i(mode), .period_i(period),
      .duty_i(duty), .pol_i(pol), .psc_i(psc), .load_i(load),
      .load_ack_o(ack), .pwm_o(pwm), .cnt_o(cnt), .period_end_o(pe)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err = 0;
   bit chk_on = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: position in the period as a phase index t, counter derived from it
   int m_psc, m_t;
   bit m_pend;
   bit s_mode, a_mode;
   int s_P, a_P;
   int s_D[CH];
   int a_D[CH];
   logic [CH-1:0] s_pol, a_pol;
   logic [CH-1:0] e_pwm;
   int e_cnt;
   bit e_pe, e_ack;

   function automatic int cnt_of(int t, int p, bit md);
      return (md && t > p) ? 2 * p - t : t;
   endfunction

   always @(posedge clk) begin
      int cur, plen;
      bit tick, last, bnd, xfer;
      if (!rst) begin
         m_psc = 0; m_t = 0; m_pend = 0;
         s_mode = 0; a_mode = 0; s_P = 0; a_P = 0; s_pol = '0; a_pol = '0;
         for (int k = 0; k < CH; k++) begin s_D[k] = 0; a_D[k] = 0; end
         e_pwm = '0; e_cnt = 0; e_pe = 0; e_ack = 0;
      end else begin
         cur = cnt_of(m_t, a_P, a_mode);
         for (int k = 0; k < CH; k++)
            e_pwm[k] = en ? ((cur < a_D[k]) ^ a_pol[k]) : a_pol[k];
         tick = en && (m_psc == int'(psc));
         plen = a_mode ? 2 * a_P : a_P + 1;
         last = (a_P == 0) || (m_t == plen - 1);
         bnd = tick && last;
         xfer = m_pend && (bnd || !en);
         e_pe = bnd;
         e_ack = xfer;
         if (!en) begin m_psc = 0; m_t = 0; end
         else if (tick) begin m_psc = 0; m_t = last ? 0 : m_t + 1; end
         else m_psc = (m_psc + 1) % 256;
         if (xfer) begin
            a_mode = s_mode; a_P = s_P; a_pol = s_pol;
            for (int k = 0; k < CH; k++) a_D[k] = s_D[k];
            m_t = 0;
         end
         if (load) begin
            s_mode = mode; s_P = int'(period); s_pol = pol;
            for (int k = 0; k < CH; k++) s_D[k] = int'(duty[k*CNT_W +: CNT_W]);
            m_pend = 1;
         end else if (xfer) begin
            m_pend = 0;
         end
         e_cnt = cnt_of(m_t, a_P, a_mode);
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("pwm_o", 32'(pwm), 32'(e_pwm));
         check("cnt_o", 32'(cnt), e_cnt);
         check("period_end_o", 32'(pe), 32'(e_pe));
         check("load_ack_o", 32'(ack), 32'(e_ack));
      end
   end

   int hi[CH];
   int n_pe, n_ack, n_cchg;
   logic [CNT_W-1:0] prev_cnt;

   task automatic clr();
      for (int k = 0; k < CH; k++) hi[k] = 0;
      n_pe = 0; n_ack = 0; n_cchg = 0; prev_cnt = cnt;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         for (int k = 0; k < CH; k++) hi[k] += int'(pwm[k]);
         n_pe += int'(pe);
         n_ack += int'(ack);
         if (cnt !== prev_cnt) n_cchg++;
         prev_cnt = cnt;
      end
   endtask

   task automatic prog(input bit md, input int p, input int d3, input int d2,
                       input int d1, input int d0, input logic [CH-1:0] pl);
      mode = md;
      period = CNT_W'(p);
      duty = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
      pol = pl;
      load = 1'b1;
      cyc(1);
      load = 1'b0;
   endtask

   task automatic wait_cnt(input int v);
      int w = 0;
      while (cnt !== CNT_W'(v) && w < 100) begin cyc(1); w++; end
      check("wait_cnt", 32'(cnt), v);
   endtask

   initial begin
      rst = 0; en = 0; mode = 0; load = 0; period = '0; duty = '0; pol = '0; psc = '0;
      clr();
      cyc(2);
      chk_on = 1;
      check("rst_pwm", 32'(pwm), 0);
      check("rst_cnt", 32'(cnt), 0);
      check("rst_pe", 32'(pe), 0);
      check("rst_ack", 32'(ack), 0);
      rst = 1;

      // Edge, P=9: ch0 D=3, ch1 D=0, ch2 D=10, ch3 D=9
      prog(0, 9, 9, 10, 0, 3, 4'h0);
      cyc(2);
      en = 1;
      cyc(30);
      clr(); cyc(10);
      check("edge_ch0_high", hi[0], 3);
      check("edge_ch1_high", hi[1], 0);
      check("edge_ch2_high", hi[2], 10);
      check("edge_ch3_high", hi[3], 9);
      check("edge_pe_count", n_pe, 1);

      // Center, P=4, D=2, inverted: counter < 2 on 3 of 8 ticks
      en = 0;
      prog(1, 4, 0, 0, 0, 2, 4'b0001);
      cyc(3);
      en = 1;
      cyc(20);
      clr(); cyc(8);
      check("center_ch0_high", hi[0], 5);
      check("center_pe_count", n_pe, 1);

      // Prescaler 1: edge P=4 D=2 -> 10-clock period, 4 high, counter moves every 2nd clock
      en = 0; psc = 1;
      prog(0, 4, 2, 2, 2, 2, 4'h0);
      cyc(3);
      en = 1;
      cyc(30);
      clr(); cyc(10);
      check("psc_ch0_high", hi[0], 4);
      check("psc_pe_count", n_pe, 1);
      check("psc_cnt_changes", n_cchg, 5);

      // Mid-period duty update
      en = 0; psc = 0;
      prog(0, 9, 0, 0, 0, 3, 4'h0);
      cyc(2);
      en = 1;
      cyc(12);
      wait_cnt(5);
      clr();
      prog(0, 9, 0, 0, 0, 7, 4'h0);
      cyc(19);
      check("mid_ack_count", n_ack, 1);
      clr(); cyc(10);
      check("mid_ch0_high", hi[0], 7);

      // Disabled load with inverted polarity, then re-enable with prescaler
      en = 0;
      clr();
      prog(0, 9, 5, 5, 5, 5, 4'hF);
      cyc(3);
      check("dis_pwm", 32'(pwm), 32'hF);
      check("dis_cnt", 32'(cnt), 0);
      check("dis_ack_count", n_ack, 1);
      psc = 2;
      en = 1;
      cyc(40);

      // Reset with a load pending
      wait_cnt(4);
      prog(1, 6, 1, 2, 3, 4, 4'h5);
      rst = 0;
      cyc(1);
      check("rst2_pwm", 32'(pwm), 0);
      check("rst2_cnt", 32'(cnt), 0);
      check("rst2_ack", 32'(ack), 0);
      rst = 1;
      clr(); cyc(20);
      check("rst2_no_ack", n_ack, 0);
      check("rst2_cnt_idle", n_cchg, 0);

      // Randomized traffic
      psc = 0;
      repeat (4000) begin
         rst = ($urandom % 400) != 0;
         if ($urandom % 60 == 0) en = ~en;
         if (!en && ($urandom % 4 == 0)) psc = PSC_W'($urandom % 3);
         load = ($urandom % 12) == 0;
         if (load) begin
            mode = 1'($urandom % 2);
            period = CNT_W'($urandom % 13);
            for (int k = 0; k < CH; k++)
               duty[k*CNT_W +: CNT_W] = ($urandom % 10 == 0) ? 16'hFFFF : CNT_W'($urandom % 15);
            pol = CH'($urandom);
         end
         cyc(1);
      end
      load = 0;
      cyc(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
